// File: rtl/la_pkg.sv
// Shared types and constants for the capture-FIFO UART drain path.
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 87;
    localparam int FRAME_BITS_8N1       = 1 + UART_DATA_BITS + 1;
    localparam int FRAME_BITS_PARITY    = FRAME_BITS_8N1 + 1;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last
// cycle of every bit; clear holds it at zero between frames.
module uart_baud_gen
    import la_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_done = !clear && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the capture FIFO one byte at a time and sends each as a UART frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module fifo_uart_tx
    import la_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       fifo_read_en,
    input  logic [7:0] fifo_read_data,
    input  logic       fifo_valid,
    output logic       tx,
    output logic       busy,
    output logic [7:0] sent_count
);

`ifdef FIFO_UART_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int FRAME_BITS = PARITY_EN ? FRAME_BITS_PARITY : FRAME_BITS_8N1;
    localparam int IDX_W      = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    state_t                  state;
    state_t                  state_next;
    logic [FRAME_BITS-1:0]   frame_q;
    logic [FRAME_BITS-1:0]   frame_load;
    logic [IDX_W-1:0]        bit_idx;
    logic                    bit_done;
    logic                    baud_clear;
    logic                    load;
    logic                    shift;
    logic                    frame_done;

`ifdef FIFO_UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

    assign frame_load = {1'b1, even_parity(fifo_read_data), fifo_read_data, 1'b0};
`else
    assign frame_load = {1'b1, fifo_read_data, 1'b0};
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The whole frame (start, data, optional parity, stop) is shifted out LSB first,
    // so the serial pin is just bit 0 while a frame is on the wire.
    always_comb begin
        state_next   = state;
        fifo_read_en = 1'b0;
        busy         = 1'b1;
        tx           = 1'b1;
        baud_clear   = 1'b1;
        load         = 1'b0;
        shift        = 1'b0;
        frame_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (enable) state_next = ST_REQ;
            end
            ST_REQ: begin
                fifo_read_en = 1'b1;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (fifo_valid) begin
                    load       = 1'b1;
                    state_next = ST_START;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_START: begin
                baud_clear = 1'b0;
                tx         = frame_q[0];
                if (bit_done) begin
                    shift      = 1'b1;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                baud_clear = 1'b0;
                tx         = frame_q[0];
                if (bit_done) begin
                    shift = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        state_next = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                baud_clear = 1'b0;
                tx         = frame_q[0];
                if (bit_done) begin
                    shift      = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                baud_clear = 1'b0;
                tx         = frame_q[0];
                if (bit_done) begin
                    frame_done = 1'b1;
                    state_next = enable ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
        end else if (load) begin
            bit_idx <= '0;
        end else if (state == ST_DATA && bit_done) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // Datapath only: contents are don't-care until loaded from the FIFO.
    always_ff @(posedge clk) begin
        if (load) begin
            frame_q <= frame_load;
        end else if (shift) begin
            frame_q <= {1'b1, frame_q[FRAME_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_count <= '0;
        end else if (frame_done) begin
            sent_count <= sent_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, frame decoder, directed table and random traffic.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_read_en;
    logic [7:0] fifo_read_data = 8'h00;
    logic       fifo_valid = 1'b0;
    logic       tx;
    logic       busy;
    logic [7:0] sent_count;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .fifo_valid     (fifo_valid),
        .tx             (tx),
        .busy           (busy),
        .sent_count     (sent_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]    fifo_q[$];
    logic          pend = 1'b0;
    int            rds[$];
    int            starts[$];
    int            ends[$];
    logic [FB-1:0] got[$];
    logic          tx_low_seen = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [9:0] frame;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic [FB-1:0] frame_of(input logic [7:0] b);
`ifdef FIFO_UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    function automatic logic [FB-1:0] tbl_frame(input vec_t v);
`ifdef FIFO_UART_TX_PARITY_EN
        return {1'b1, v.par, v.frame[8:0]};
`else
        return v.frame;
`endif
    endfunction

    // Registered FIFO: valid/data appear the cycle after a read request.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend       = 1'b0;
            fifo_valid = 1'b0;
        end else begin
            fifo_valid = 1'b0;
            if (pend) begin
                fifo_valid     = 1'b1;
                fifo_read_data = fifo_q.pop_front();
            end
            pend = fifo_read_en && (fifo_q.size() > 0);
        end
    end

    // Line monitor: decodes frames from the tx pin, independent of DUT internals.
    int             k = 0;
    logic           in_frame = 1'b0;
    logic           prev_tx = 1'b1;
    logic           busy_ok = 1'b1;
    logic [FL-1:0]  samp = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame = 1'b0;
            prev_tx  = 1'b1;
        end else begin
            if (fifo_read_en === 1'b1) rds.push_back(cyc);
            if (tx === 1'b0) tx_low_seen = 1'b1;
            if (!in_frame && prev_tx === 1'b1 && tx === 1'b0) begin
                in_frame = 1'b1;
                k        = 0;
                busy_ok  = 1'b1;
                starts.push_back(cyc);
                check("req_to_start", (rds.size() > 0) ? cyc - rds[$] : -1, 2);
            end
            if (in_frame) begin
                samp[k] = tx;
                if (busy !== 1'b1) busy_ok = 1'b0;
                k++;
                if (k == FL) begin
                    logic [FB-1:0] f;
                    int bad;
                    bad = 0;
                    for (int j = 0; j < FB; j++) begin
                        f[j] = samp[j*C];
                        for (int m = 0; m < C; m++)
                            if (samp[j*C+m] !== samp[j*C]) bad++;
                    end
                    check("bit_shape", bad, 0);
                    check("busy_in_frame", busy_ok, 1);
                    in_frame = 1'b0;
                    ends.push_back(cyc);
                    got.push_back(f);
                end
            end
            prev_tx = tx;
        end
    end

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n  = 1'b0;
        enable = 1'b0;
        fifo_q.delete();
        repeat (2) @(negedge clk);
        #1;
        got.delete(); rds.delete(); starts.delete(); ends.delete();
        tx_low_seen = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (got.size() < n && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        if (got.size() < n) check("timeout_frames", got.size(), n);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int t;
        t = 0;
        while (starts.size() < n && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        if (starts.size() < n) check("timeout_start", starts.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sent_exp[$];
        int prev;
        int n;

        tbl[0] = '{8'hA5, 1'b0, 10'b1_10100101_0};
        tbl[1] = '{8'h00, 1'b0, 10'b1_00000000_0};
        tbl[2] = '{8'hFF, 1'b0, 10'b1_11111111_0};
        tbl[3] = '{8'h3C, 1'b0, 10'b1_00111100_0};
        tbl[4] = '{8'h81, 1'b0, 10'b1_10000001_0};
        tbl[5] = '{8'h07, 1'b1, 10'b1_00000111_0};
        tbl[6] = '{8'h03, 1'b0, 10'b1_00000011_0};

        // Reset values, held in reset
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_read_en", fifo_read_en, 0);
        check("rst_busy", busy, 0);
        check("rst_sent_count", sent_count, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("idle_no_request", rds.size(), 0);
        check("idle_busy", busy, 0);

        // Table: back-to-back frames with enable held
        do_reset();
        for (int i = 0; i < 7; i++) fifo_q.push_back(tbl[i].data);
        enable = 1'b1;
        wait_frames(7, 7 * (FL + 3) + 50);
        for (int i = 0; i < 7; i++)
            if (i < got.size()) check("table_frame", got[i], tbl_frame(tbl[i]));
        for (int i = 0; i < 6; i++)
            if (i + 1 < starts.size()) check("interframe_gap", starts[i+1] - ends[i] - 1, 2);
        @(negedge clk); #1;
        check("table_sent_count", sent_count, 7);
        repeat (12) @(negedge clk);
        #1;
        check("no_extra_frames", got.size(), 7);
        if (ends.size() == 7) begin
            prev = ends[6] - 2;
            n = 0;
            foreach (rds[i]) begin
                if (rds[i] > ends[6]) begin
                    check("poll_after_drain", rds[i] - prev, 3);
                    prev = rds[i];
                    n++;
                end
            end
            check("poll_after_drain_count", n, 5);
        end
        check("drain_tx_idle", tx, 1);

        // Empty FIFO with enable high: poll loop only
        do_reset();
        enable = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("poll_count", rds.size(), 10);
        for (int i = 1; i < rds.size(); i++) check("poll_spacing", rds[i] - rds[i-1], 3);
        check("poll_tx_high", tx_low_seen, 0);
        check("poll_sent_count", sent_count, 0);
        check("poll_no_frames", got.size(), 0);

        // Enable dropped during data bit 3: frame completes, no further request
        do_reset();
        fifo_q.push_back(8'h81);
        fifo_q.push_back(8'h55);
        enable = 1'b1;
        wait_starts(1, 20);
        repeat (4 * C + 1) @(negedge clk);
        #1;
        enable = 1'b0;
        wait_frames(1, FL + 10);
        check("stop_last_busy", busy, 1);
        check("stop_last_count", sent_count, 0);
        @(negedge clk); #1;
        check("after_stop_busy", busy, 0);
        check("after_stop_count", sent_count, 1);
        if (got.size() > 0) check("drop_en_frame", got[0], frame_of(8'h81));
        repeat (10) @(negedge clk);
        #1;
        check("drop_en_requests", rds.size(), 1);
        check("drop_en_fifo_left", fifo_q.size(), 1);

        // Asynchronous reset in the middle of a data bit
        enable = 1'b1;
        wait_starts(2, 20);
        repeat (3 * C) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_count", sent_count, 0);
        @(negedge clk); #1;
        got.delete(); rds.delete(); starts.delete(); ends.delete();
        fifo_q.push_back(8'h66);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_request", rds.size(), 1);
        wait_frames(1, FL + 10);
        if (got.size() > 0) check("post_rst_frame", got[0], frame_of(8'h66));
        @(negedge clk); #1;
        check("post_rst_count", sent_count, 1);

        // Random traffic with enable toggling: every byte sent once, in order
        do_reset();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [7:0] b;
                b = 8'($urandom);
                fifo_q.push_back(b);
                sent_exp.push_back(b);
            end
            enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 15)) @(negedge clk);
            #1;
        end
        enable = 1'b1;
        wait_frames(sent_exp.size(), sent_exp.size() * (FL + 3) + 100);
        enable = 1'b0;
        check("rand_frame_total", got.size(), sent_exp.size());
        foreach (sent_exp[i])
            if (i < got.size()) check("rand_frame", got[i], frame_of(sent_exp[i]));
        repeat (3) @(negedge clk);
        #1;
        check("rand_sent_count", sent_count, 8'(sent_exp.size()));
        check("rand_idle_tx", tx, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain side of the capture FIFO: pulls captured bytes one at a time using the FIFO's read_en / read_data / valid handshake and serializes each as an 8N1 UART frame on a single output pin. Sits between the capture FIFO and the chip output pad; it is the only reader of the FIFO.

## Interface
- CLKS_PER_BIT, default 87: clk cycles per UART bit (≈115200 baud at 10 MHz); legal range 2..65535.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; when high, block requests bytes from the FIFO.
- fifo_read_en  out  1  one-cycle read request to the FIFO.
- fifo_read_data  in  8  byte returned by the FIFO, registered by the FIFO.
- fifo_valid  in  1  one-cycle pulse, the cycle after fifo_read_en, when fifo_read_data holds a real byte.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high from the request cycle through the end of the stop bit.
- sent_count  out  8  number of frames completed, wraps 255→0.

## Operation
- States: IDLE, REQ, WAIT, START, DATA, STOP (plus PARITY when configured).
- IDLE: tx=1, busy=0. If enable=1 → REQ.
- REQ: fifo_read_en=1 for exactly this cycle, busy=1 → WAIT.
- WAIT: sample fifo_valid. If 1: latch fifo_read_data into shift register, reset baud counter → START. If 0 (FIFO empty): → IDLE, busy=0.
- START: tx=0 for CLKS_PER_BIT cycles → DATA, bit index 0.
- DATA: tx = shift[0], LSB first; each bit held CLKS_PER_BIT cycles; after bit 7 → STOP (or PARITY).
- STOP: tx=1 for CLKS_PER_BIT cycles; on last cycle sent_count increments; → REQ if enable=1, else IDLE.
- fifo_valid outside WAIT is ignored (never occurs with a conforming FIFO).
- fifo_read_en is never asserted outside REQ; at most one outstanding request.
- Baud counter: width ceil(log2(CLKS_PER_BIT)), counts 0..CLKS_PER_BIT-1, wraps to 0 on bit boundary.

## Timing
- Reset values: tx=1, fifo_read_en=0, busy=0, sent_count=0, state IDLE, counters 0.
- Request to start bit: fifo_read_en high at cycle N, fifo_valid at N+1, tx falls at N+2.
- Frame length: 10·CLKS_PER_BIT cycles (11· with parity) from tx falling edge to end of stop bit.
- Back-to-back: with enable held and FIFO non-empty, next fifo_read_en is the cycle after the stop bit ends; inter-frame idle-high gap = 2 cycles beyond the stop bit.
- Empty FIFO with enable high: REQ/WAIT/IDLE poll loop, one read_en every 3 cycles, tx stays 1.
- enable deasserted mid-frame: current frame completes fully, no further request.
- enable deasserted in REQ/WAIT: request still completes; a returned byte is still transmitted (never dropped).
- Reset mid-frame: tx returns to 1 asynchronously; in-flight byte is lost; sent_count clears.

## Configuration
- FIFO_UART_TX_PARITY_EN defined: PARITY state inserted after DATA; tx = even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles; frame 11 bits.
- Undefined: no PARITY state, 8N1, 10-bit frame.

## Structure
- Shared package la_pkg: state enum type, UART_DATA_BITS=8, default CLKS_PER_BIT, frame-length constants.
- One sub-module: uart_baud_gen (parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output bit_done pulse on last cycle of each bit).

## Test plan
- CLKS_PER_BIT=4, FIFO model holds 0xA5, enable=1 → read_en one cycle, tx: 0, 1,0,1,0,0,1,0,1, 1, each 4 cycles; sent_count=1.
- FIFO holds 0x00,0xFF,0x3C, enable held → three frames, each preceded by one read_en, 2-cycle gap between stop and next start; sent_count=3; then poll loop with tx=1.
- Empty FIFO, enable=1 for 30 cycles → read_en every 3 cycles, fifo_valid never high, tx constant 1, sent_count=0.
- enable dropped during DATA bit 3 of 0x81 → frame finishes correctly, no further read_en, busy falls after stop bit.
- rst_n asserted mid DATA → tx=1, busy=0, sent_count=0 immediately; after release with enable=1 a fresh request follows.
- With FIFO_UART_TX_PARITY_EN, byte 0x07 → parity bit 1, frame 44 cycles; byte 0x03 → parity bit 0.
